// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan scheduler.
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StBlank
  } scan_state_t;

  localparam int unsigned DIGIT_W_DEF      = 4;
  localparam int unsigned BLANK_CYCLES_DEF = 2;
  localparam int unsigned MAX_DIGITS       = 8;

  // One-hot digit enable for a digit index (up to MAX_DIGITS digits).
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] r;
    r = MAX_DIGITS'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_bank.sv
// Shadow and display digit register files with write port and frame-boundary copy.
module seg7_digit_bank #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_addr_i,
  input  logic [DIGIT_W-1:0] wr_data_i,
  input  logic               copy_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [DIGIT_W-1:0] rd_data_o
);

  logic [DIGIT_W-1:0] shadow_q  [NUM_DIGITS];
  logic [DIGIT_W-1:0] display_q [NUM_DIGITS];

  // Writes go to the shadow bank; copy publishes the whole shadow bank at once.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i]  <= '0;
        display_q[i] <= '0;
      end
    end else begin
      if (wr_en_i) shadow_q[wr_addr_i] <= wr_data_i;
      if (copy_i)  display_q <= shadow_q;
    end
  end

  // Read-through on a copy edge so the first digit of the new frame shows the new bank.
  assign rd_data_o = copy_i ? shadow_q[rd_idx_i] : display_q[rd_idx_i];

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Multiplexed 7-segment scan scheduler: FSM, dwell prescaler, blanking and write handshake.
module seg7_scan_scheduler
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_W      = DIGIT_W_DEF,
  parameter int unsigned RATE_W       = 8,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          scan_en,
  input  logic [RATE_W-1:0]             rate,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [DIGIT_W-1:0]            wr_data,
  input  logic                          commit,
  output logic                          commit_pending,
  output logic [DIGIT_W-1:0]            digit_val,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          blank,
  output logic                          frame_start
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned BlankW = $clog2(BLANK_CYCLES + 1);

  scan_state_t         state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [RATE_W-1:0]   presc_q, presc_d;
  logic [BlankW-1:0]   blank_cnt_q, blank_cnt_d;
  logic [RATE_W-1:0]   rate_q;
  logic                pending_q;
  logic [DIGIT_W-1:0]  digit_val_q;
  logic [NUM_DIGITS-1:0] digit_en_q, en_next;
  logic                blank_q, frame_start_q;
  logic                boundary, copy, wr_en;
  logic [DIGIT_W-1:0]  rd_data;

  assign wr_en = wr_valid && !pending_q;
  assign copy  = boundary && pending_q;

  seg7_digit_bank #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIGIT_W   (DIGIT_W),
    .IDX_W     (IdxW)
  ) u_bank (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .copy_i   (copy),
    .rd_idx_i (idx_d),
    .rd_data_o(rd_data)
  );

  // Next-state: scan sequencing, dwell/blank counters and frame-boundary detection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    presc_d     = presc_q;
    blank_cnt_d = blank_cnt_q;
    boundary    = 1'b0;
    if (!scan_en) begin
      state_d     = StIdle;
      idx_d       = '0;
      presc_d     = '0;
      blank_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StShow;
          idx_d    = '0;
          presc_d  = '0;
          boundary = 1'b1;
        end
        StShow: begin
          if (presc_q == rate_q) begin
            state_d     = StBlank;
            presc_d     = '0;
            blank_cnt_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        StBlank: begin
          if (blank_cnt_q == BlankW'(BLANK_CYCLES - 1)) begin
            state_d     = StShow;
            blank_cnt_d = '0;
            idx_d       = idx_q + 1'b1;
            boundary    = (idx_q == IdxW'(NUM_DIGITS - 1));
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    en_next = NUM_DIGITS'(onehot(3'(idx_d)));
  end

  // State, latched rate, pending flag and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      presc_q       <= '0;
      blank_cnt_q   <= '0;
      rate_q        <= '0;
      pending_q     <= 1'b0;
      digit_val_q   <= '0;
      digit_en_q    <= '0;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      presc_q       <= presc_d;
      blank_cnt_q   <= blank_cnt_d;
      if (boundary) rate_q <= rate;
      // A commit on the copy edge re-arms for the following frame.
      pending_q     <= (pending_q && !copy) || commit;
      frame_start_q <= boundary;
      if (state_d == StShow) begin
        digit_en_q  <= en_next;
        digit_val_q <= rd_data;
        blank_q     <= 1'b0;
      end else begin
        digit_en_q  <= '0;
        blank_q     <= 1'b1;
      end
    end
  end

  assign wr_ready       = !pending_q;
  assign commit_pending = pending_q;
  assign digit_val      = digit_val_q;
  assign digit_en       = digit_en_q;
  assign blank          = blank_q;
  assign frame_start    = frame_start_q;

endmodule

// File: doc/seg7_scan_scheduler.md
Name: seg7_scan_scheduler

Overview:
- Time-multiplexes NUM_DIGITS 4-bit digit values onto the single shared hex-to-7-segment decoder datapath.
- Drives a one-hot digit enable and inserts a blanking gap between digits to prevent ghosting.
- Writers load a shadow bank through a valid/ready handshake. A commit request copies the shadow bank into the display bank at the next frame boundary, so a frame never tears.

Parameters:
- NUM_DIGITS, 4: digits scanned per frame; power of two, 2..8.
- DIGIT_W, 4: width of each digit value, matching the decoder input.
- RATE_W, 8: width of the per-digit dwell prescaler.
- BLANK_CYCLES, 2: clock cycles of all-off gap between digits; must be >= 1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous reset, active low.
- scan_en  in  1  1 = scan; 0 = park in IDLE.
- rate  in  RATE_W  dwell per digit = rate+1 cycles; sampled at frame boundary.
- wr_valid  in  1  shadow write request.
- wr_ready  out  1  shadow write accepted when wr_valid&&wr_ready.
- wr_addr  in  clog2(NUM_DIGITS)  shadow digit index.
- wr_data  in  DIGIT_W  shadow digit value.
- commit  in  1  single-cycle request to publish shadow bank.
- commit_pending  out  1  high from commit until the frame-boundary copy.
- digit_val  out  DIGIT_W  value presented to the decoder.
- digit_en  out  NUM_DIGITS  one-hot common-line enable; all zero when blank.
- blank  out  1  decoder output must be forced off.
- frame_start  out  1  one-cycle pulse on entry to SHOW of digit 0.

Behaviour:
- Reset (rst_n=0 at a clk edge) takes effect synchronously:
  - state=IDLE.
  - Shadow and display banks are all 0.
  - digit_val=0, digit_en=0, blank=1, frame_start=0.
  - commit_pending=0, wr_ready=1.
  - Prescaler, blank counter and index are 0; latched rate is 0.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - blank=1, digit_en=0.
  - When scan_en=1, next state is SHOW with idx=0, rate latched, frame_start pulses.
- SHOW:
  - digit_en=1<<idx, digit_val=display[idx], blank=0.
  - Dwell lasts exactly latched_rate+1 cycles, then BLANK.
- BLANK:
  - digit_en=0, blank=1, digit_val holds its last value.
  - Lasts exactly BLANK_CYCLES cycles, then SHOW with idx+1 mod NUM_DIGITS.
- Frame boundary is the BLANK->SHOW transition with wrap to idx=0. At that transition:
  - rate is re-latched.
  - If commit_pending=1, display bank <= shadow bank (same edge) and commit_pending <= 0.
  - frame_start pulses in the first cycle of the new SHOW.
- scan_en=0 in any state: next state is IDLE, idx=0, counters cleared. A pending commit stays pending.
- Leaving IDLE also counts as a frame boundary, so any pending commit is applied and the new bank shows at once.
- Handshake:
  - wr_ready = !commit_pending. Writes are stalled while a commit waits, so the shadow bank stays stable.
  - An accepted write updates shadow[wr_addr] on the same edge.
  - wr_addr >= NUM_DIGITS is impossible by width, since NUM_DIGITS is a power of two.
- commit while commit_pending=1: ignored; a single pending flag only.
- commit and a write accepted in the same cycle: the write lands in the shadow bank first and is included in the commit.
- commit in the very cycle a boundary copy occurs:
  - The copy uses the old pending flag.
  - A new commit sets commit_pending again for the next frame.
- rate change mid-frame: no effect until the next boundary.
- rate=0: dwell is 1 cycle. Frame length = NUM_DIGITS*(rate+1+BLANK_CYCLES) cycles.
- All outputs are registered; digit_en and digit_val change on the same edge.

Decomposition:
- Shared package seg7_pkg:
  - scan_state_t enum {IDLE, SHOW, BLANK}.
  - Constants DIGIT_W_DEF=4 and BLANK_CYCLES_DEF=2.
  - Function for onehot(idx).
- One sub-module: seg7_digit_bank. It holds the shadow and display register files, the write port and the commit copy, and has a combinational read port for idx.
- The FSM, prescaler and handshake stay in the top module.

Test Plan:
- Reset, then scan_en=1, rate=3, bank all 0 -> frame_start at cycle 1; digit_en pattern 0001 x4, 0000 x2, 0010 x4, ...; frame length 24 cycles.
- Write digits {1,2,3,4} to addr 0..3, commit mid-frame -> commit_pending=1 and wr_ready=0 until the boundary; next frame shows digit_val 1,2,3,4 with matching one-hot; no change before the boundary.
- Write with wr_valid=1 while commit_pending=1 -> wr_ready=0, shadow unchanged; the write completes the cycle after the boundary.
- Change rate 3->0 mid-frame -> current frame keeps 4-cycle dwell; next frame uses 1-cycle dwell, frame length 12.
- scan_en=0 during SHOW of digit 2 -> next cycle digit_en=0, blank=1; re-enable -> resumes at digit 0 with frame_start and applies a pending commit.
- Assert rst_n=0 mid-BLANK with commit pending -> next edge all outputs take reset values, commit_pending=0, display bank 0.
